console_uart_bridge: RTL
========================

Name: console_uart_bridge

Overview:
- Memory-mapped console sink on the core's data memory interface, downstream of the data port.
- Captures byte writes to the console address into a FIFO and drains them as 8N1 serial frames on a TX pin.
- Replaces the simulation-only character write with synthesizable hardware.
- Also exposes a read-only status word and a sticky overflow flag.

Parameters:
- CONSOLE_ADDRESS, 32'h1000_0000: byte-write data port.
- STATUS_ADDRESS, 32'h1000_0004: status port. A read returns status; a write clears overflow.
- FIFO_DEPTH, 16: character FIFO entries. Must be a power of two, 2..128.
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_memory_interface_enable  input  1  bus access strobe.
- data_memory_interface_state  input  1  access direction, compared against the codebase READ/WRITE defines.
- data_memory_interface_address  input  32  byte address.
- data_memory_interface_frame_mask  input  4  byte-lane enables; bit[3] selects data[7:0].
- data_memory_interface_write_data  input  32  store data.
- status_read_data  output  32  status word.
- status_read_valid  output  1  high for one cycle when status_read_data is valid.
- uart_tx  output  1  serial line; idles high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.

Behaviour:
- Reset values (asynchronous, while reset=1):
  - FIFO empty; read pointer, write pointer and count = 0; overflow = 0.
  - TX state = IDLE; uart_tx = 1; busy = 0.
  - status_read_data = 0; status_read_valid = 0.
  - Reset mid-frame aborts the frame immediately and discards FIFO contents; uart_tx returns to 1 asynchronously.
- Push:
  - Condition at a rising edge: enable=1, state=WRITE, address==CONSOLE_ADDRESS and frame_mask[3]=1.
  - Effect: data[7:0] is written at the write pointer.
  - Other lanes and other addresses are ignored.
- Overflow:
  - A push while count==FIFO_DEPTH with no same-cycle pop drops the byte and sets overflow=1.
  - Overflow stays set until a write to STATUS_ADDRESS.
  - If a clear and an overflowing push occur in the same cycle, overflow ends at 1.
- Pointers:
  - Both are log2(FIFO_DEPTH) bits wide and wrap naturally.
  - count is log2(FIFO_DEPTH)+1 bits wide.
  - A simultaneous push and pop on a full FIFO accepts the push; count stays at FIFO_DEPTH and overflow is not set.
  - A push into an empty FIFO is never popped in the same cycle.
- Status read:
  - Condition: enable=1, state=READ, address==STATUS_ADDRESS.
  - Next edge: status_read_valid=1 and status_read_data={16'b0, count zero-extended to 8 bits, 5'b0, overflow, full, empty}.
  - Both outputs are registered. status_read_valid returns to 0 on the following edge unless the read repeats.
- TX state machine (IDLE, START, DATA, STOP) with a bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1):
  - IDLE: if FIFO non-empty, pop the head into the shift register, uart_tx<=0, go to START.
  - START: hold for CLKS_PER_BIT cycles, then drive bit0 and go to DATA.
  - DATA: shift out LSB-first, each bit held CLKS_PER_BIT cycles. After bit7, uart_tx<=1 and go to STOP.
  - STOP: hold high for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency and framing:
  - A push at edge N into an empty FIFO with TX in IDLE gives the falling start edge at edge N+1.
  - One frame lasts exactly 10*CLKS_PER_BIT cycles.
- busy = (count!=0) || (state!=IDLE), registered.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Write 0x41 ('A') to 0x1000_0000 with mask 4'b1000 at edge N -> uart_tx low at N+1. Line then carries 0,1,0,0,0,0,0,1,0,1, each for 4 cycles; high and busy=0 after 40 cycles.
2. Write "HI" on consecutive cycles -> two frames back-to-back, 80 cycles total, with no high gap between the 'H' stop bit and the 'I' start bit.
3. Six writes on consecutive cycles while idle -> the first is popped at once; the sixth is dropped. A status read returns 0x0000_0406 (count 4, overflow 1, full 1). Exactly five frames are transmitted.
4. Write 0x5A with mask 4'b0100, and 0x5A to 0x1000_0008 with mask 4'b1000 -> no push; status read returns 0x0000_0001.
5. Assert reset during bit 3 of a frame with 2 bytes queued -> uart_tx=1 immediately; status then reads 0x0000_0001; no further frames.
6. Overflow set, then a write to 0x1000_0004 -> the next status read has bit2=0; status_read_valid is high for exactly one cycle.

Source files
------------

// File: rtl/console_uart_bridge.sv
// Console sink on the data memory bus: byte writes to the console address are
// queued in a FIFO and sent out as 8N1 frames; a status word reports FIFO state.
module console_uart_bridge #(
  parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDRESS  = 32'h1000_0004,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned CLKS_PER_BIT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_memory_interface_enable,
  input  logic        data_memory_interface_state,
  input  logic [31:0] data_memory_interface_address,
  input  logic [3:0]  data_memory_interface_frame_mask,
  input  logic [31:0] data_memory_interface_write_data,
  output logic [31:0] status_read_data,
  output logic        status_read_valid,
  output logic        uart_tx,
  output logic        busy
);

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  logic [7:0] fifo_mem [FIFO_DEPTH];

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic [31:0] status_data_q, status_data_d;
  logic        status_valid_q, status_valid_d;

  logic push_req, clear_req, read_req;
  logic fifo_empty, fifo_full;
  logic pop, push_ok;

  always_comb begin
    push_req  = data_memory_interface_enable
             && (data_memory_interface_state == WRITE)
             && (data_memory_interface_address == CONSOLE_ADDRESS)
             && data_memory_interface_frame_mask[3];
    clear_req = data_memory_interface_enable
             && (data_memory_interface_state == WRITE)
             && (data_memory_interface_address == STATUS_ADDRESS);
    read_req  = data_memory_interface_enable
             && (data_memory_interface_state == READ)
             && (data_memory_interface_address == STATUS_ADDRESS);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    push_ok  = push_req && (!fifo_full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A dropped push wins over a same-cycle clear.
    overflow_d = clear_req ? 1'b0 : overflow_q;
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;

    busy_d = (count_d != '0) || (state_d != IDLE);

    status_valid_d = read_req;
    status_data_d  = read_req
                   ? {16'b0, 8'(count_q), 5'b0, overflow_q, fifo_full, fifo_empty}
                   : status_data_q;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= data_memory_interface_write_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      baud_q         <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      tx_q           <= 1'b1;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      status_data_q  <= '0;
      status_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      baud_q         <= baud_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      tx_q           <= tx_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
      status_data_q  <= status_data_d;
      status_valid_q <= status_valid_d;
    end
  end

  assign uart_tx           = tx_q;
  assign busy              = busy_q;
  assign status_read_data  = status_data_q;
  assign status_read_valid = status_valid_q;

endmodule
